// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache between the MEM stage and a line-wide memory.
// Hits: 0 cycles. Misses hold p1_stall_o for memory latency + 1 cycles.
module dcache_controller #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p1_req_i,
  input  logic                  p1_write_i,
  input  logic [31:0]           p1_addr_i,
  input  logic [31:0]           p1_data_i,
  output logic [31:0]           p1_data_o,
  output logic                  p1_stall_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [31:0]           mem_addr_o,
  output logic [32*WORDS-1:0]   mem_data_o,
  input  logic [32*WORDS-1:0]   mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 28 - IDX_W;
  localparam int LINE_W = 32 * WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [LINES-1:0]        dirty_q, dirty_d;
  logic [TAG_W-1:0]        tag_q [LINES];
  logic [TAG_W-1:0]        tag_d [LINES];
  logic [LINE_W-1:0]       data_q [LINES];
  logic [LINE_W-1:0]       data_d [LINES];
  logic [TAG_W-1:0]        miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]        miss_idx_q, miss_idx_d;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              word;
  logic                    hit;
  logic                    unused_addr_bits;

  assign idx              = p1_addr_i[4 +: IDX_W];
  assign tag              = p1_addr_i[31 -: TAG_W];
  assign word             = p1_addr_i[3:2];
  assign hit              = p1_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign unused_addr_bits = ^p1_addr_i[1:0];

  // The missing line's tag/index are latched so the memory transaction
  // completes intact even if the CPU withdraws the request mid-miss.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    case (state_q)
      IDLE: begin
        if (p1_req_i) begin
          if (hit) begin
            if (p1_write_i) begin
              data_d[idx][{word, 5'd0} +: 32] = p1_data_i;
              dirty_d[idx]                    = 1'b1;
            end
          end else begin
            miss_tag_d = tag;
            miss_idx_d = idx;
            state_d    = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          data_d[miss_idx_q]  = mem_data_i;
          tag_d[miss_idx_q]   = miss_tag_q;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      tag_q      <= '{default: '0};
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Line storage is left out of reset; valid bits alone gate its use.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  always_comb begin
    p1_stall_o   = (state_q != IDLE) | (p1_req_i & ~hit);
    p1_data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (hit && !p1_write_i) p1_data_o = data_q[idx][{word, 5'd0} +: 32];
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, 4'b0};
        mem_data_o   = data_q[miss_idx_q];
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, 4'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed accesses push expected memory
// transactions and CPU results; a negedge monitor pops and compares them.
module tb_dcache_controller;

  logic         clk;
  logic         rst_i;
  logic         p1_req_i;
  logic         p1_write_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller #(.LINES(16), .WORDS(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_req_i     (p1_req_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  localparam logic [127:0] F40   = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] WB40  = 128'h0000000D_0000000C_12345678_0000000A;
  localparam logic [127:0] F140  = 128'h00000143_00000142_00000141_00000140;
  localparam logic [127:0] F240  = 128'h00000243_00000242_00000241_00000240;
  localparam logic [127:0] F340  = 128'h00000343_00000342_00000341_00000340;
  localparam logic [127:0] WB340 = 128'h00000343_CAFEF00D_00000341_00000340;
  localparam logic [127:0] F010  = 128'h00000013_00000012_00000011_00000010;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] line;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  mem_exp_t mem_q [$];
  cpu_exp_t cpu_q [$];

  int           checks = 0;
  int           errors = 0;
  logic         mem_auto;
  int           mem_lat;
  logic [127:0] fill_line;
  logic         manual_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void exp_mem(input logic wr, input logic [31:0] a, input logic [127:0] l);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.line = l;
    mem_q.push_back(e);
  endfunction

  function automatic void exp_cpu(input logic [31:0] d, input int s);
    cpu_exp_t e;
    e.data = d; e.stall = s;
    cpu_q.push_back(e);
  endfunction

  // Memory responder: acks after mem_lat cycles of mem_enable_o, or on demand.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      if (manual_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = {4{32'h5555_5555}};
        wait_cnt   = 0;
      end else if (mem_auto && mem_enable_o) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          mem_ack_i  = 1'b1;
          mem_data_i = fill_line;
          wait_cnt   = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: memory transaction starts and completed CPU accesses.
  initial begin
    logic     prev_en, prev_wr;
    int       stall_cnt;
    mem_exp_t me;
    cpu_exp_t ce;
    prev_en = 1'b0; prev_wr = 1'b0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_enable_o && (!prev_en || (prev_wr && !mem_write_o))) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_txn: unexpected transaction wr=%b addr=%h", mem_write_o, mem_addr_o);
        end else begin
          me = mem_q.pop_front();
          check("mem_write", {127'd0, mem_write_o}, {127'd0, me.wr});
          check("mem_addr", {96'd0, mem_addr_o}, {96'd0, me.addr});
          if (me.wr) check("mem_data", mem_data_o, me.line);
        end
      end
      prev_en = mem_enable_o;
      prev_wr = mem_write_o;
      if (p1_req_i) begin
        if (p1_stall_o) stall_cnt++;
        else begin
          if (cpu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpu_done: unexpected completion addr=%h", p1_addr_i);
          end else begin
            ce = cpu_q.pop_front();
            check("p1_data", {96'd0, p1_data_o}, {96'd0, ce.data});
            check("stall_cycles", 128'(stall_cnt), 128'(ce.stall));
          end
          stall_cnt = 0;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
    @(negedge clk);
    while (p1_stall_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL cpu_timeout: addr=%h still stalled after %0d cycles", a, n);
    end
    @(posedge clk); #1;
    p1_req_i = 1'b0; p1_write_i = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_stall"}, {127'd0, p1_stall_o}, 128'd0);
    check({name, "_mem_en"}, {127'd0, mem_enable_o}, 128'd0);
    check({name, "_mem_addr"}, {96'd0, mem_addr_o}, 128'd0);
    check({name, "_p1_data"}, {96'd0, p1_data_o}, 128'd0);
  endtask

  initial begin
    rst_i = 1'b0; p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    mem_auto = 1'b1; mem_lat = 1; fill_line = '0; manual_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    check_quiet("reset");
    check("reset_mem_write", {127'd0, mem_write_o}, 128'd0);
    check("reset_mem_data", mem_data_o, 128'd0);

    // Cold miss, 10-cycle memory
    mem_lat = 10; fill_line = F40;
    exp_mem(1'b0, 32'h40, '0); exp_cpu(32'hA, 11);
    cpu_access(1'b0, 32'h40, '0);

    // Store hit then load (byte offset ignored)
    exp_cpu(32'h0, 0);
    cpu_access(1'b1, 32'h44, 32'h1234_5678);
    exp_cpu(32'h1234_5678, 0);
    cpu_access(1'b0, 32'h47, '0);

    // Dirty conflict: write-back then allocate
    mem_lat = 3; fill_line = F140;
    exp_mem(1'b1, 32'h40, WB40); exp_mem(1'b0, 32'h140, '0); exp_cpu(32'h140, 7);
    cpu_access(1'b0, 32'h140, '0);

    // Clean conflict: allocate only
    mem_lat = 2; fill_line = F240;
    exp_mem(1'b0, 32'h240, '0); exp_cpu(32'h242, 3);
    cpu_access(1'b0, 32'h248, '0);

    // Store miss merges into filled line
    mem_lat = 1; fill_line = F340;
    exp_mem(1'b0, 32'h340, '0); exp_cpu(32'h0, 2);
    cpu_access(1'b1, 32'h348, 32'hCAFE_F00D);
    exp_cpu(32'h343, 0);
    cpu_access(1'b0, 32'h34C, '0);

    // Another index, then evict the merged dirty line
    mem_lat = 4; fill_line = F010;
    exp_mem(1'b0, 32'h10, '0); exp_cpu(32'h10, 5);
    cpu_access(1'b0, 32'h10, '0);
    mem_lat = 2; fill_line = F40;
    exp_mem(1'b1, 32'h340, WB340); exp_mem(1'b0, 32'h40, '0); exp_cpu(32'hB, 5);
    cpu_access(1'b0, 32'h44, '0);

    // Reset in the middle of ALLOCATE, then a late ack
    mem_auto = 1'b0;
    exp_mem(1'b0, 32'h80, '0);
    @(posedge clk); #1;
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h80;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0; p1_req_i = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    check_quiet("abort");
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    check("late_ack_mem_en", {127'd0, mem_enable_o}, 128'd0);
    @(negedge clk);
    check_quiet("after_late_ack");
    mem_auto = 1'b1; mem_lat = 2; fill_line = F40;
    exp_mem(1'b0, 32'h40, '0); exp_cpu(32'hA, 3);
    cpu_access(1'b0, 32'h40, '0);

    // Stray ack while IDLE and idle CPU
    @(negedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    check_quiet("idle_ack");
    @(negedge clk);
    check_quiet("after_idle_ack");
    exp_cpu(32'hA, 0);
    cpu_access(1'b0, 32'h40, '0);
    exp_cpu(32'hB, 0);
    cpu_access(1'b0, 32'h44, '0);

    for (int i = 0; i < 50 && (mem_q.size() + cpu_q.size()) != 0; i++) @(negedge clk);
    check("queues_drained", 128'(mem_q.size() + cpu_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have parameters: LINES, default 16, number of direct-mapped lines; WORDS, default 4, 32-bit words per line (fixed at 4 in this revision).
REQ-003 clk_i  input  1  pipeline clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  synchronous active-low reset.
REQ-005 p1_req_i  input  1  MEM-stage access request (MemRead or MemWrite asserted).
REQ-006 p1_write_i  input  1  1 = store, 0 = load; valid with p1_req_i.
REQ-007 p1_addr_i  input  32  byte address (ALU result); bits [1:0] ignored.
REQ-008 p1_data_i  input  32  store data (RT data).
REQ-009 p1_data_o  output  32  load data.
REQ-010 p1_stall_o  output  1  freeze PC, IFID, IDEX, EXMEM, MEMWB while high.
REQ-011 mem_enable_o  output  1  memory request valid.
REQ-012 mem_write_o  output  1  1 = line write-back, 0 = line fill.
REQ-013 mem_addr_o  output  32  line-aligned memory address.
REQ-014 mem_data_o  output  128  write-back line data.
REQ-015 mem_data_i  input  128  fill line data; valid when mem_ack_i high.
REQ-016 mem_ack_i  input  1  one-cycle completion pulse from data memory.

Function
REQ-017 Address split: offset word = addr[3:2], index = addr[7:4], tag = addr[31:8] (24 bits); word w occupies line bits [32w+31:32w].
REQ-018 Per line: valid bit, dirty bit, 24-bit tag, 128-bit data; write-back, write-allocate policy.
REQ-019 hit = p1_req_i & valid[index] & (tag[index] == addr tag), combinational.
REQ-020 FSM states IDLE, WRITEBACK, ALLOCATE; reset state IDLE.
REQ-021 IDLE, hit: p1_stall_o = 0; load drives addressed word on p1_data_o same cycle; store writes p1_data_i into addressed word and sets dirty at the next edge.
REQ-022 IDLE, p1_req_i & !hit: p1_stall_o = 1 same cycle; next state WRITEBACK if valid & dirty, else ALLOCATE.
REQ-023 WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {stored tag, index, 4'b0}, mem_data_o = stored line; held stable until mem_ack_i; on ack -> ALLOCATE.
REQ-024 ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {addr tag, index, 4'b0}; on ack, line data <= mem_data_i, tag <= addr tag, valid <= 1, dirty <= 0, -> IDLE.
REQ-025 After refill, IDLE re-evaluates the held access as a hit: p1_stall_o drops the cycle after the fill edge; a store merges into the filled line then.
REQ-026 p1_stall_o = 1 in WRITEBACK and ALLOCATE regardless of p1_req_i.
REQ-027 p1_data_o = 32'h0 whenever not (IDLE & hit & !p1_write_i).
REQ-028 In IDLE mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
REQ-029 mem_ack_i while IDLE SHALL be ignored with no state change.
REQ-030 CPU holds p1_req_i/p1_addr_i/p1_write_i/p1_data_i stable while p1_stall_o = 1; if p1_req_i drops mid-miss the current memory transaction and fill still complete, then IDLE.
REQ-031 Miss latency = memory latency(s) + 1 cycle; hit latency 0.

Reset
REQ-032 rst_i = 0 at an edge: state IDLE, all valid and dirty bits 0, tags 0; data array not reset.
REQ-033 Reset mid-WRITEBACK/ALLOCATE aborts: mem_enable_o = 0 from the following cycle, dirty data discarded, late mem_ack_i ignored.

Verification
REQ-034 After reset, load 0x0000_0040: p1_stall_o = 1; ALLOCATE, mem_addr_o = 0x40; ack after 10 cycles with mem_data_i = {32'hD,32'hC,32'hB,32'hA} -> next cycle stall = 0, p1_data_o = 0xA.
REQ-035 Store 0x0000_0044 data 0x1234_5678 (hit) -> no stall; subsequent load 0x44 returns 0x1234_5678; line 4 dirty.
REQ-036 Load 0x0000_0140 (index 4, tag 1) -> WRITEBACK, mem_write_o = 1, mem_addr_o = 0x40, mem_data_o[63:32] = 0x1234_5678; after ack, ALLOCATE mem_addr_o = 0x140.
REQ-037 Load 0x0000_0240 after clean fill of 0x140 -> no WRITEBACK; ALLOCATE mem_addr_o = 0x240 directly.
REQ-038 rst_i = 0 during ALLOCATE -> mem_enable_o = 0 and p1_stall_o = 0 next cycle; late ack ignored; load 0x40 misses again.
REQ-039 mem_ack_i pulse in IDLE with p1_req_i = 0 -> no output or state change.
